cpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 8-bit CPU. It fetches instruction bytes over a valid-qualified request interface and decodes them. It drives the shared `alu_8bit` operands and `alu_sel`, and owns a 4×8 register file whose contents it writes back. It sits between instruction memory and the ALU and replaces the purely combinational `control_unit` path with a sequenced machine.

---
 rtl/cpu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU with a 4x8 register file.
// Optional feature: define CPU_SEQ_JZ_EN to turn opcode 111 with nonzero [4:0] into JZ.
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] pc_out,
    output logic       instr_req,
    input  logic [7:0] instr_in,
    input  logic       instr_valid,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data,
    output logic       zero_flag,
    output logic       carry_flag,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXEC      = 3'd3,
        FETCH_IMM = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [7:0]  ir_reg, ir_next;
    logic [7:0]  rf_reg [4];
    logic        zero_reg, carry_reg;
    logic        instr_req_reg, busy_reg, halted_reg;

    logic        wr_en;
    logic [7:0]  wr_data;
    logic        flags_en;
    logic [3:0]  rf_we;

    logic [2:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        is_jz;

    assign opcode = ir_reg[7:5];
    assign rd     = ir_reg[4:3];
    assign rs     = ir_reg[2:1];

`ifdef CPU_SEQ_JZ_EN
    assign is_jz = (opcode == 3'b111) && (ir_reg[4:0] != 5'd0);
`else
    assign is_jz = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        wr_en      = 1'b0;
        wr_data    = alu_result;
        flags_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (instr_valid) begin
                    ir_next    = instr_in;
                    pc_next    = pc_reg + 8'd1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (opcode == 3'b110 || is_jz) begin
                    state_next = FETCH_IMM;
                end else if (opcode == 3'b111) begin
                    state_next = HALT;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                wr_en      = 1'b1;
                flags_en   = 1'b1;
                state_next = FETCH;
            end
            FETCH_IMM: begin
                if (instr_valid) begin
                    state_next = FETCH;
                    if (is_jz) begin
                        // Flag is the one left by the last ALU op, not this instruction.
                        pc_next = zero_reg ? instr_in : pc_reg + 8'd1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_data = instr_in;
                        pc_next = pc_reg + 8'd1;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rf_we
            assign rf_we[gi] = wr_en && (rd == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pc_reg        <= 8'd0;
            ir_reg        <= 8'd0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            instr_req_reg <= 1'b0;
            busy_reg      <= 1'b0;
            halted_reg    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf_reg[i] <= 8'd0;
            end
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            ir_reg        <= ir_next;
            instr_req_reg <= (state_next == FETCH) || (state_next == FETCH_IMM);
            busy_reg      <= (state_next != IDLE) && (state_next != HALT);
            halted_reg    <= (state_next == HALT);
            if (flags_en) begin
                zero_reg  <= (alu_result == 8'd0);
                carry_reg <= alu_carry;
            end
            for (int i = 0; i < 4; i++) begin
                if (rf_we[i]) begin
                    rf_reg[i] <= wr_data;
                end
            end
        end
    end

    // ALU inputs stay at zero except while executing so the shared ALU is quiet.
    always_comb begin
        alu_a   = 8'd0;
        alu_b   = 8'd0;
        alu_sel = 3'd0;
        if (state_reg == EXEC) begin
            alu_a   = rf_reg[rd];
            alu_b   = rf_reg[rs];
            alu_sel = opcode;
        end
    end

    assign dbg_data   = rf_reg[dbg_sel];
    assign pc_out     = pc_reg;
    assign instr_req  = instr_req_reg;
    assign busy       = busy_reg;
    assign halted     = halted_reg;
    assign zero_flag  = zero_reg;
    assign carry_flag = carry_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction memory and ALU models plus a scoreboard.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pc_out;
    logic       instr_req;
    logic [7:0] instr_in;
    logic       instr_valid;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    logic       zero_flag;
    logic       carry_flag;
    logic       busy;
    logic       halted;

    cpu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pc_out     (pc_out),
        .instr_req  (instr_req),
        .instr_in   (instr_in),
        .instr_valid(instr_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign instr_in = mem[pc_out];

    // Bench ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, 5 shift left.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'd0;
        case (alu_sel)
            3'd0: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_wide = {1'b0, alu_a & alu_b};
            3'd3: alu_wide = {1'b0, alu_a | alu_b};
            3'd4: alu_wide = {1'b0, alu_a ^ alu_b};
            3'd5: alu_wide = {alu_a, 1'b0};
            default: alu_wide = 9'd0;
        endcase
    end
    assign alu_result = alu_wide[7:0];
    assign alu_carry  = alu_wide[8];

    typedef struct {
        logic [7:0] instr;
        logic [7:0] imm;
        int         stall;
        logic [1:0] rd;
        logic [7:0] val;
        logic       z;
        logic       c;
        logic [7:0] pc;
        int         cycles;
    } vec_t;

    vec_t       vecs [13];
    vec_t       exp_q [$];
    logic [7:0] tb_pc;
    int         checks;
    int         failures;
    int         txn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT waiting in FETCH at tb_pc and instr_valid low.
    task automatic run_vec(input vec_t v);
        vec_t       e;
        int         n;
        logic       done;
        logic [7:0] nxt;
        nxt = tb_pc + 8'd1;
        mem[tb_pc] = v.instr;
        mem[nxt]   = v.imm;
        exp_q.push_back(v);
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            instr_valid = (n >= v.stall);
            @(negedge clk);
            n++;
            if (n <= v.stall) begin
                chk("stall_req", {31'd0, instr_req}, 32'd1);
                chk("stall_pc", {24'd0, pc_out}, {24'd0, tb_pc});
            end
            if (instr_req) begin
                chk("alu_quiet", {13'd0, alu_sel, alu_a, alu_b}, 32'd0);
            end
            if (instr_req && pc_out == v.pc) done = 1'b1;
        end
        instr_valid = 1'b0;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d instr=%02h pc=%02h cycles=%0d", txn, e.instr, pc_out, n);
        chk("completion", {31'd0, done}, 32'd1);
        dbg_sel = e.rd;
        #1;
        chk("reg", {24'd0, dbg_data}, {24'd0, e.val});
        chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.z});
        chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.c});
        chk("cycles", n, e.cycles);
        tb_pc = e.pc;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tb_pc = 8'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pc"}, {24'd0, pc_out}, 32'd0);
        chk({tag, "_ctl"}, {28'd0, instr_req, busy, halted, zero_flag}, 32'd0);
        chk({tag, "_carry"}, {31'd0, carry_flag}, 32'd0);
        chk({tag, "_alu"}, {13'd0, alu_sel, alu_a, alu_b}, 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            chk({tag, "_reg"}, {24'd0, dbg_data}, 32'd0);
        end
    endtask

    initial begin
        int n;
        checks = 0;
        failures = 0;
        txn = 0;
        rst = 1'b1;
        start = 1'b0;
        instr_valid = 1'b0;
        dbg_sel = 2'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h7E;

        //        instr  imm    stall rd    val    z     c     pc     cycles
        vecs[0]  = '{8'hC8, 8'h05, 0, 2'd1, 8'h05, 1'b0, 1'b0, 8'h02, 3};
        vecs[1]  = '{8'hD0, 8'h03, 0, 2'd2, 8'h03, 1'b0, 1'b0, 8'h04, 3};
        vecs[2]  = '{8'h0C, 8'h00, 0, 2'd1, 8'h08, 1'b0, 1'b0, 8'h05, 3};
        vecs[3]  = '{8'hC0, 8'hFF, 0, 2'd0, 8'hFF, 1'b0, 1'b0, 8'h07, 3};
        vecs[4]  = '{8'hD8, 8'h01, 0, 2'd3, 8'h01, 1'b0, 1'b0, 8'h09, 3};
        vecs[5]  = '{8'h06, 8'h00, 0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h0A, 3};
        vecs[6]  = '{8'hD0, 8'h0A, 4, 2'd2, 8'h0A, 1'b1, 1'b1, 8'h0C, 7};
        vecs[7]  = '{8'h2C, 8'h00, 4, 2'd1, 8'hFE, 1'b0, 1'b1, 8'h0D, 7};
        vecs[8]  = '{8'h4E, 8'h00, 0, 2'd1, 8'h00, 1'b1, 1'b0, 8'h0E, 3};
        vecs[9]  = '{8'h7E, 8'h00, 0, 2'd3, 8'h01, 1'b0, 1'b0, 8'h0F, 3};
        vecs[10] = '{8'h94, 8'h00, 0, 2'd2, 8'h00, 1'b1, 1'b0, 8'h10, 3};
        vecs[11] = '{8'hC8, 8'h81, 0, 2'd1, 8'h81, 1'b1, 1'b0, 8'h12, 3};
        vecs[12] = '{8'hA8, 8'h00, 0, 2'd1, 8'h02, 1'b0, 1'b1, 8'h13, 3};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req", {30'd0, instr_req, busy}, 32'd0);

        do_start();
        chk("start_req", {30'd0, instr_req, busy}, 32'd3);
        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Walk the PC up to 0xFE with single-byte ops, then cross the wrap.
        for (int a = 8'h13; a < 8'hFE; a++) mem[a] = 8'h7E;
        n = 0;
        instr_valid = 1'b1;
        while (!(instr_req && pc_out == 8'hFE) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        instr_valid = 1'b0;
        chk("reach_fe", {24'd0, pc_out}, 32'hFE);
        tb_pc = 8'hFE;
        run_vec('{8'h7E, 8'h00, 0, 2'd3, 8'h01, 1'b0, 1'b0, 8'hFF, 3});
        run_vec('{8'h7E, 8'h00, 0, 2'd3, 8'h01, 1'b0, 1'b0, 8'h00, 3});

        mem[0] = 8'hE0;
        instr_valid = 1'b1;
        wait_halt(n);
        $display("txn halt pc=%02h cycles=%0d", pc_out, n);
        chk("halt_cycles", n, 2);
        chk("halt_state", {29'd0, halted, busy, instr_req}, 32'd4);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        instr_valid = 1'b0;
        chk("halt_sticky", {29'd0, halted, busy, instr_req}, 32'd4);
        chk("halt_pc", {24'd0, pc_out}, 32'h01);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("halt_reset", {30'd0, halted, busy}, 32'd0);

        // Fill registers and flags, then reset mid-FETCH with start and a late valid.
        do_start();
        run_vec('{8'hD0, 8'h5A, 0, 2'd2, 8'h5A, 1'b0, 1'b0, 8'h02, 3});
        run_vec('{8'hC0, 8'h80, 0, 2'd0, 8'h80, 1'b0, 1'b0, 8'h04, 3});
        run_vec('{8'h00, 8'h00, 0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h05, 3});
        @(negedge clk);
        chk("mid_fetch_req", {31'd0, instr_req}, 32'd1);
        rst = 1'b1;
        start = 1'b1;
        instr_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        $display("txn reset_mid_fetch pc=%02h", pc_out);
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        instr_valid = 1'b0;
        chk("post_reset_idle", {23'd0, pc_out, instr_req}, 32'd0);

        do_start();
        run_vec('{8'hC0, 8'h00, 0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h02, 3});
        run_vec('{8'h00, 8'h00, 0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h03, 3});
`ifdef CPU_SEQ_JZ_EN
        run_vec('{8'hE2, 8'h40, 0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h40, 3});
        run_vec('{8'hC8, 8'h01, 0, 2'd1, 8'h01, 1'b1, 1'b0, 8'h42, 3});
        run_vec('{8'h6A, 8'h00, 0, 2'd1, 8'h01, 1'b0, 1'b0, 8'h43, 3});
        run_vec('{8'hE2, 8'h50, 0, 2'd1, 8'h01, 1'b0, 1'b0, 8'h45, 3});
        chk("jz_not_halted", {31'd0, halted}, 32'd0);
`else
        mem[3] = 8'hE2;
        instr_valid = 1'b1;
        wait_halt(n);
        instr_valid = 1'b0;
        $display("txn e2_halt pc=%02h cycles=%0d", pc_out, n);
        chk("e2_halts", {31'd0, halted}, 32'd1);
        chk("e2_cycles", n, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
